// File: rtl/core_eei_pkg.sv
// Core execution-environment constants and the fetch buffer entry layout.
package core_eei;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned ILEN           = 32;
  localparam int unsigned MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] inst;
  } fetch_entry;

endpackage

// File: rtl/core_fifo.sv
// Synchronous FIFO with same-cycle push/pop and a flush that overrides both.
module core_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Sequential instruction fetcher with credit-limited issue, redirect flush and response drop.
// Optional perf counters enabled by defining INST_FETCHER_PERF_CNT_EN.
module inst_fetcher import core_eei::*; #(
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            membus_valid,
  input  logic            membus_ready,
  output logic [XLEN-1:0] membus_addr,
  output logic            membus_wen,
  output logic [ILEN-1:0] membus_wdata,
  input  logic            membus_rvalid,
  input  logic [ILEN-1:0] membus_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_addr,
  output logic [ILEN-1:0] if_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef INST_FETCHER_PERF_CNT_EN
  ,
  output logic [63:0]     perf_issued,
  output logic [63:0]     perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] resp_pc, resp_pc_next;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   inflight, inflight_next;
  logic [CW-1:0]   drop, drop_next;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            credit_ok, accept, resp_drop, push, pop;
  fetch_entry      push_entry, head;
  logic            sig_unused;

  assign sig_unused    = ^{fifo_full, redirect_pc[1:0]};
  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  // Buffered plus outstanding entries must fit, so every response has a slot
  assign credit_ok    = (SW'(fifo_count) + SW'(inflight)) < SW'(FIFO_DEPTH);
  assign membus_valid = credit_ok && !redirect_valid && !rst;
  assign accept       = membus_valid && membus_ready;
  assign membus_addr  = fetch_pc;
  assign membus_wen   = 1'b0;
  assign membus_wdata = '0;

  assign resp_drop  = membus_rvalid && (redirect_valid || (drop != '0));
  assign push       = membus_rvalid && !resp_drop;
  assign pop        = !fifo_empty && if_ready && !redirect_valid;
  assign push_entry = '{addr: resp_pc, inst: membus_rdata};

  assign if_valid = !fifo_empty;
  assign if_addr  = fifo_empty ? '0 : head.addr;
  assign if_inst  = fifo_empty ? '0 : head.inst;

  core_fifo #(
    .WIDTH($bits(fetch_entry)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(push_entry),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Next-state for PCs and the in-flight / drop counters
  always_comb begin
    fetch_pc_next = fetch_pc;
    resp_pc_next  = resp_pc;
    inflight_next = inflight + CW'(accept) - CW'(membus_rvalid);
    drop_next     = drop;
    if (redirect_valid) begin
      fetch_pc_next = redirect_base;
      resp_pc_next  = redirect_base;
      // Everything still outstanding after this cycle belongs to the old stream
      drop_next     = inflight_next;
    end else begin
      if (accept)                          fetch_pc_next = fetch_pc + XLEN'(4);
      if (push)                            resp_pc_next  = resp_pc + XLEN'(4);
      if (membus_rvalid && (drop != '0))   drop_next     = drop - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      resp_pc  <= resp_pc_next;
      inflight <= inflight_next;
      drop     <= drop_next;
    end
  end

`ifdef INST_FETCHER_PERF_CNT_EN
  // Saturating counters, untouched by redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_dropped <= '0;
    end else begin
      if (accept && (perf_issued != '1))     perf_issued  <= perf_issued + 64'(1);
      if (resp_drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 64'(1);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher with a 1-cycle (stallable) memory model.
module tb_inst_fetcher;
  import core_eei::*;

  logic            clk, rst;
  logic            membus_valid, membus_ready, membus_wen, membus_rvalid;
  logic [XLEN-1:0] membus_addr;
  logic [ILEN-1:0] membus_wdata, membus_rdata;
  logic            if_valid, if_ready;
  logic [XLEN-1:0] if_addr;
  logic [ILEN-1:0] if_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef INST_FETCHER_PERF_CNT_EN
  logic [63:0]     perf_issued, perf_dropped;
`endif

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  logic            resp_en;
  logic [XLEN-1:0] acc_q[$];
  logic [XLEN-1:0] pend_q[$];
  logic [XLEN-1:0] del_q[$];

  inst_fetcher dut (
    .clk           (clk),
    .rst           (rst),
    .membus_valid  (membus_valid),
    .membus_ready  (membus_ready),
    .membus_addr   (membus_addr),
    .membus_wen    (membus_wen),
    .membus_wdata  (membus_wdata),
    .membus_rvalid (membus_rvalid),
    .membus_rdata  (membus_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_addr       (if_addr),
    .if_inst       (if_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef INST_FETCHER_PERF_CNT_EN
    ,
    .perf_issued   (perf_issued),
    .perf_dropped  (perf_dropped)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [ILEN-1:0] memf(input logic [XLEN-1:0] a);
    return ILEN'(32'hDEAD_0000 + a);
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock: log accepts/deliveries before the edge, then drive the memory response
  task automatic tick();
    logic            acc;
    logic [XLEN-1:0] a;
    acc = membus_valid && membus_ready;
    a   = membus_addr;
    if (acc) begin
      n_acc++;
      acc_q.push_back(a);
    end
    if (if_valid && if_ready && !redirect_valid) del_q.push_back(if_addr);
    @(posedge clk);
    #1;
    if (acc) pend_q.push_back(a);
    if (resp_en && (pend_q.size() > 0)) begin
      membus_rvalid = 1'b1;
      membus_rdata  = memf(pend_q.pop_front());
    end else begin
      membus_rvalid = 1'b0;
      membus_rdata  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    membus_ready   = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_en        = 1'b1;
    pend_q.delete();
    acc_q.delete();
    del_q.delete();
    n_acc = 0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    membus_ready   = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_en        = 1'b1;
    pend_q.delete();
    n_acc = 0;
    tick();
    tick();
    checks++;
    if (membus_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_membus_valid: got %b expected 0", membus_valid);
    end
    checks++;
    if ({if_valid, if_addr, if_inst} !== {1'b0, XLEN'(0), ILEN'(0)}) begin
      failures++;
      $display("FAIL reset_if: got valid=%b addr=%h inst=%h expected 0/0/0", if_valid, if_addr, if_inst);
    end
    checks++;
    if (n_acc !== 0) begin
      failures++;
      $display("FAIL reset_no_accept: got %0d expected 0", n_acc);
    end
    rst = 1'b0;
    settle();
    checks++;
    if ({membus_valid, membus_addr} !== {1'b1, XLEN'(0)}) begin
      failures++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", membus_valid, membus_addr);
    end
    checks++;
    if ({membus_wen, membus_wdata} !== {1'b0, ILEN'(0)}) begin
      failures++;
      $display("FAIL tie_wen_wdata: got wen=%b wdata=%h expected 0/0", membus_wen, membus_wdata);
    end
  endtask

  task automatic test_stream();
    do_reset();
    membus_ready = 1'b1;
    if_ready     = 1'b1;
    settle();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({membus_valid, membus_addr} !== {1'b1, XLEN'(4 * k)}) begin
        failures++;
        $display("FAIL stream_req[%0d]: got valid=%b addr=%h expected 1/%h", k, membus_valid, membus_addr, XLEN'(4 * k));
      end
      if (k >= 2) begin
        checks++;
        if ({if_valid, if_addr, if_inst} !== {1'b1, XLEN'(4 * (k - 2)), memf(XLEN'(4 * (k - 2)))}) begin
          failures++;
          $display("FAIL stream_out[%0d]: got valid=%b addr=%h inst=%h expected 1/%h/%h", k, if_valid, if_addr,
                   if_inst, XLEN'(4 * (k - 2)), memf(XLEN'(4 * (k - 2))));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    membus_ready = 1'b1;
    if_ready     = 1'b0;
    settle();
    repeat (10) tick();
    checks++;
    if (n_acc !== 4) begin
      failures++;
      $display("FAIL bp_accepts: got %0d expected 4", n_acc);
    end
    checks++;
    if (membus_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_valid_low: got %b expected 0", membus_valid);
    end
    checks++;
    if ({if_valid, if_addr} !== {1'b1, XLEN'(0)}) begin
      failures++;
      $display("FAIL bp_head: got valid=%b addr=%h expected 1/00000000", if_valid, if_addr);
    end
    if_ready = 1'b1;
    settle();
    tick();
    if_ready = 1'b0;
    settle();
    repeat (6) tick();
    checks++;
    if (n_acc !== 5) begin
      failures++;
      $display("FAIL bp_one_more: got %0d expected 5", n_acc);
    end
    checks++;
    if (acc_q[$] !== XLEN'(32'h10)) begin
      failures++;
      $display("FAIL bp_new_addr: got %h expected 00000010", acc_q[$]);
    end
    checks++;
    if ({if_valid, if_addr, membus_valid} !== {1'b1, XLEN'(4), 1'b0}) begin
      failures++;
      $display("FAIL bp_after_pop: got valid=%b addr=%h mvalid=%b expected 1/00000004/0", if_valid, if_addr, membus_valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    membus_ready = 1'b1;
    if_ready     = 1'b1;
    settle();
    repeat (4) tick();
    membus_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({membus_valid, membus_addr} !== {1'b1, XLEN'(32'h10)}) begin
        failures++;
        $display("FAIL hold[%0d]: got valid=%b addr=%h expected 1/00000010", i, membus_valid, membus_addr);
      end
      tick();
    end
    membus_ready = 1'b1;
    settle();
    checks++;
    if ({membus_valid, membus_addr} !== {1'b1, XLEN'(32'h10)}) begin
      failures++;
      $display("FAIL hold_release: got valid=%b addr=%h expected 1/00000010", membus_valid, membus_addr);
    end
    tick();
    checks++;
    if ({n_acc, acc_q[$]} !== {32'd5, XLEN'(32'h10)}) begin
      failures++;
      $display("FAIL hold_accept: got n=%0d addr=%h expected 5/00000010", n_acc, acc_q[$]);
    end
  endtask

  task automatic test_redirect();
    bit found;
    do_reset();
    membus_ready = 1'b1;
    if_ready     = 1'b1;
    resp_en      = 1'b0;
    settle();
    tick();
    tick();
    checks++;
    if (n_acc !== 2) begin
      failures++;
      $display("FAIL redir_inflight: got %0d expected 2", n_acc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h103);
    settle();
    checks++;
    if (membus_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_valid_low: got %b expected 0", membus_valid);
    end
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    settle();
    checks++;
    if ({membus_valid, membus_addr} !== {1'b1, XLEN'(32'h100)}) begin
      failures++;
      $display("FAIL redir_req: got valid=%b addr=%h expected 1/00000100", membus_valid, membus_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (if_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redir_timeout: got no if_valid expected one within 12 cycles");
    end else if ({if_addr, if_inst} !== {XLEN'(32'h100), memf(XLEN'(32'h100))}) begin
      failures++;
      $display("FAIL redir_first: got addr=%h inst=%h expected 00000100/%h", if_addr, if_inst, memf(XLEN'(32'h100)));
    end
`ifdef INST_FETCHER_PERF_CNT_EN
    checks++;
    if (perf_dropped !== 64'd2) begin
      failures++;
      $display("FAIL perf_dropped: got %0d expected 2", perf_dropped);
    end
    checks++;
    if (perf_issued !== 64'(n_acc)) begin
      failures++;
      $display("FAIL perf_issued: got %0d expected %0d", perf_issued, n_acc);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit bad;
    do_reset();
    membus_ready = 1'b1;
    if_ready     = 1'b1;
    resp_en      = 1'b0;
    settle();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h200);
    settle();
    tick();
    redirect_pc = XLEN'(32'h300);
    settle();
    checks++;
    if (membus_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_low: got %b expected 0", membus_valid);
    end
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    del_q.delete();
    settle();
    checks++;
    if ({membus_valid, membus_addr} !== {1'b1, XLEN'(32'h300)}) begin
      failures++;
      $display("FAIL b2b_req: got valid=%b addr=%h expected 1/00000300", membus_valid, membus_addr);
    end
    repeat (12) tick();
    checks++;
    if (del_q.size() < 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected >=4", del_q.size());
    end else if ({del_q[0], del_q[1], del_q[2]} !== {XLEN'(32'h300), XLEN'(32'h304), XLEN'(32'h308)}) begin
      failures++;
      $display("FAIL b2b_stream: got %h %h %h expected 00000300 00000304 00000308", del_q[0], del_q[1], del_q[2]);
    end
    bad = 1'b0;
    foreach (del_q[i]) if (del_q[i][XLEN-1:8] == (XLEN - 8)'(2)) bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_0x2xx: got delivery from 0x2xx expected none");
    end
  endtask

  initial begin
    rst            = 1'b1;
    membus_ready   = 1'b0;
    membus_rvalid  = 1'b0;
    membus_rdata   = '0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_en        = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_redirect();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
